// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide
// on operand magnitudes, one radix-2 step per cycle, single op in flight.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      funct3,
  input  logic [4:0]      rd,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic            kill,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [4:0]      out_rd,
  output logic [XLEN-1:0] out_data
);
  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  typedef struct packed {
    logic [2:0]      op;
    logic            neg;   // final result needs negation
    logic [XLEN-1:0] b;     // multiplicand / divisor magnitude
  } req_t;

  state_t            state_q, state_d;
  req_t              req_q, req_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [4:0]        out_rd_q, out_rd_d;
  logic [XLEN-1:0]   out_data_q, out_data_d;

  logic            accept, last, fast;
  logic            s1, s2, n1, n2;
  logic [XLEN-1:0] a_abs, b_abs, fast_res;
  logic [XLEN:0]   sum, rsh;
  logic [XLEN-1:0] rdiff, dv, dres, mres;
  logic            ge;
  logic [2*XLEN-1:0] mstep, dstep, step, mul_s;

  assign accept = in_valid && !kill && (state_q == IDLE);
  assign last   = (cnt_q == CW'(XLEN-1));

  // Operand preparation at accept
  always_comb begin
    s1 = (funct3 != 3'b011) && (funct3 != 3'b101) && (funct3 != 3'b111);
    s2 = s1 && (funct3 != 3'b010);
    n1 = s1 && src1[XLEN-1];
    n2 = s2 && src2[XLEN-1];
    a_abs = n1 ? -src1 : src1;
    b_abs = n2 ? -src2 : src2;
    fast = 1'b0;
    fast_res = '0;
    if (funct3[2]) begin
      if (src2 == '0) begin
        fast = 1'b1;
        fast_res = funct3[1] ? src1 : '1;
      end else if (!funct3[0] && src1 == {1'b1, {(XLEN-1){1'b0}}} && src2 == '1) begin
        fast = 1'b1;
        fast_res = funct3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
      end
    end
  end

  // One iteration step plus final sign correction
  always_comb begin
    sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, req_q.b} : '0);
    mstep = {sum, acc_q[XLEN-1:1]};
    rsh   = acc_q[2*XLEN-1:XLEN-1];
    ge    = (rsh >= {1'b0, req_q.b});
    rdiff = rsh[XLEN-1:0] - req_q.b;
    dstep = {(ge ? rdiff : rsh[XLEN-1:0]), acc_q[XLEN-2:0], ge};
    step  = req_q.op[2] ? dstep : mstep;
    mul_s = req_q.neg ? -step : step;
    mres  = (req_q.op == 3'b000) ? mul_s[XLEN-1:0] : mul_s[2*XLEN-1:XLEN];
    dv    = req_q.op[1] ? step[2*XLEN-1:XLEN] : step[XLEN-1:0];
    dres  = req_q.neg ? -dv : dv;
  end

  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (kill) state_d = IDLE;
    else begin
      case (state_q)
        IDLE:    if (in_valid) state_d = fast ? DONE : CALC;
        CALC:    if (last) state_d = DONE;
        DONE:    if (out_ready) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
  end

  always_comb begin
    req_d      = req_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    out_rd_d   = out_rd_q;
    out_data_d = out_data_q;
    if (accept) begin
      req_d.op   = funct3;
      req_d.neg  = (funct3[2] && funct3[1]) ? n1 : (n1 ^ n2);
      req_d.b    = b_abs;
      acc_d      = {{XLEN{1'b0}}, a_abs};
      cnt_d      = '0;
      out_rd_d   = rd;
      if (fast) out_data_d = fast_res;
    end else if (state_q == CALC) begin
      acc_d = step;
      cnt_d = cnt_q + 1'b1;
      if (last) out_data_d = req_q.op[2] ? dres : mres;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      req_q      <= '0;
      cnt_q      <= '0;
      acc_q      <= '0;
      out_rd_q   <= '0;
      out_data_q <= '0;
    end else begin
      req_q      <= req_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      out_rd_q   <= out_rd_d;
      out_data_q <= out_data_d;
    end
  end

  assign out_rd   = out_rd_q;
  assign out_data = out_data_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit; expected results queued at issue, checked at write-back.
module tb_muldiv_unit;
  logic        clk = 1'b0;
  logic        rst, in_valid, kill, out_ready, in_ready, out_valid;
  logic [2:0]  funct3;
  logic [4:0]  rd, out_rd;
  logic [31:0] src1, src2, out_data;

  int total = 0;
  int bad = 0;
  logic [36:0] sb[$];

  muldiv_unit #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .funct3(funct3), .rd(rd), .src1(src1), .src2(src2), .kill(kill),
    .out_valid(out_valid), .out_ready(out_ready), .out_rd(out_rd), .out_data(out_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic start_op(input logic [2:0] f, input logic [4:0] r, input logic [31:0] a, input logic [31:0] b);
    funct3 = f; rd = r; src1 = a; src2 = b; in_valid = 1'b1;
    chk("in_ready_before_accept", in_ready, 1);
    step();
    in_valid = 1'b0; funct3 = 3'($urandom); rd = 5'($urandom); src1 = $urandom; src2 = $urandom;
  endtask

  // returns number of edges from accept until out_valid seen (bounded)
  task automatic wait_valid(output int n);
    n = 1;
    while (!out_valid && n < 200) begin step(); n++; end
  endtask

  task automatic run_op(input logic [2:0] f, input logic [4:0] r, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat, input int hold);
    int n;
    logic [36:0] e;
    logic [31:0] d0;
    logic [4:0]  r0;
    out_ready = (hold == 0);
    sb.push_back({r, exp});
    start_op(f, r, a, b);
    wait_valid(n);
    chk("latency", n, lat);
    chk("out_valid", out_valid, 1);
    if (sb.size() == 0) chk("scoreboard_empty", 1, 0);
    else begin
      e = sb.pop_front();
      chk("out_data", out_data, e[31:0]);
      chk("out_rd", out_rd, e[36:32]);
    end
    d0 = out_data; r0 = out_rd;
    for (int i = 0; i < hold; i++) begin
      step();
      chk("hold_valid", out_valid, 1);
      chk("hold_data", out_data, d0);
      chk("hold_rd", out_rd, r0);
      chk("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    step();
    chk("post_hs_valid", out_valid, 0);
    chk("post_hs_in_ready", in_ready, 1);
  endtask

  initial begin
    int n, seen;
    rst = 1'b0; in_valid = 1'b0; kill = 1'b0; out_ready = 1'b1;
    funct3 = '0; rd = '0; src1 = '0; src2 = '0;
    step(); step();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_rd", out_rd, 0);
    chk("rst_out_data", out_data, 0);
    rst = 1'b1;
    step();

    run_op(3'b000, 5'd5,  32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33, 0);
    run_op(3'b001, 5'd6,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 33, 0);
    run_op(3'b010, 5'd7,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, 0);
    run_op(3'b011, 5'd8,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33, 0);
    run_op(3'b100, 5'd9,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33, 0);
    run_op(3'b110, 5'd10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33, 0);
    run_op(3'b101, 5'd11, 32'd100,      32'd7,        32'd14,       33, 0);
    run_op(3'b111, 5'd0,  32'd100,      32'd7,        32'd2,        33, 0);
    run_op(3'b000, 5'd12, 32'h12345678, 32'hFEDCBA98, 32'h35068740, 33, 0);
    run_op(3'b101, 5'd13, 32'd5,        32'd0,        32'hFFFFFFFF, 1,  0);
    run_op(3'b110, 5'd14, 32'd5,        32'd0,        32'd5,        1,  0);
    run_op(3'b100, 5'd15, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1,  0);
    run_op(3'b110, 5'd16, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1,  0);
    run_op(3'b000, 5'd17, 32'd3,        32'd5,        32'd15,       33, 10);

    // kill beats a DONE handshake in the same cycle
    out_ready = 1'b0;
    start_op(3'b000, 5'd3, 32'd6, 32'd7);
    wait_valid(n);
    chk("kd_latency", n, 33);
    chk("kd_data", out_data, 42);
    out_ready = 1'b1; kill = 1'b1;
    step();
    kill = 1'b0;
    chk("kd_valid", out_valid, 0);
    chk("kd_in_ready", in_ready, 1);

    // kill mid-calc at cnt=10
    start_op(3'b000, 5'd4, 32'd9, 32'd9);
    repeat (10) step();
    chk("k_busy", in_ready, 0);
    kill = 1'b1;
    step();
    kill = 1'b0;
    chk("k_valid", out_valid, 0);
    chk("k_in_ready", in_ready, 1);
    seen = 0;
    for (int i = 0; i < 40; i++) begin step(); if (out_valid) seen++; end
    chk("k_no_result", seen, 0);

    // reset mid-calc at cnt=10
    start_op(3'b100, 5'd21, 32'd1000, 32'd3);
    repeat (10) step();
    rst = 1'b0;
    step();
    chk("r_valid", out_valid, 0);
    chk("r_in_ready", in_ready, 1);
    chk("r_out_rd", out_rd, 0);
    chk("r_out_data", out_data, 0);
    rst = 1'b1;
    step();
    run_op(3'b000, 5'd1, 32'd3, 32'd4, 32'd12, 33, 0);

    chk("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide execution unit sitting between register-file read and write-back.
- Consumes rs1/rs2 operand values read from the GPR file; produces a 32-bit result plus destination index for the GPR write port (waddr/wdata/RegWEn).
- One operation in flight; valid/ready handshake on both sides; kill input discards in-flight work on pipeline flush.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported. Iteration count equals XLEN.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  unit can accept a request; high only in IDLE.
- funct3  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- rd  in  5  destination register index.
- src1  in  32  rs1 value.
- src2  in  32  rs2 value.
- kill  in  1  abort any accepted or completed op.
- out_valid  out  1  result valid; drives write-back enable.
- out_ready  in  1  write-back accepts result.
- out_rd  out  5  destination index of result.
- out_data  out  32  result value.

Behaviour:
- Reset (rst==0 at edge): state IDLE, counter 0, out_valid 0, out_rd 0, out_data 0, in_ready 1 in the following cycle.
- States: IDLE, CALC, DONE.
- IDLE: in_ready=1. Accept on edge with in_valid && !kill: latch funct3, rd, src1, src2, precomputed signs and absolute values. Next state CALC with cnt=0, except the fast path below.
- Fast path (divide only), next state DONE directly:
  - src2==0: DIV/DIVU -> 0xFFFFFFFF; REM/REMU -> src1.
  - DIV with src1=0x80000000 and src2=0xFFFFFFFF -> 0x80000000; REM with the same operands -> 0.
- CALC: one radix-2 step per cycle.
  - Multiply: shift-add of unsigned magnitudes into a 64-bit product.
  - Divide: restoring division on unsigned magnitudes, 32-bit quotient and remainder.
  - After the step with cnt==31, go to DONE; otherwise cnt+1.
- Sign rules:
  - MUL/MULH/DIV/REM treat both operands as signed.
  - MULHSU treats src1 as signed, src2 as unsigned.
  - MULHU/DIVU/REMU treat both as unsigned.
  - Product is negated when operand signs differ.
  - Quotient is negated when signs differ; remainder takes the sign of the dividend.
  - MUL returns product[31:0]; MULH/MULHSU/MULHU return product[63:32].
- Result latching: the final sign correction is applied when entering DONE, and out_data is registered.
- Latency:
  - Normal ops: out_valid first high in the cycle after the 32nd CALC edge, i.e. 33 edges after the accept edge.
  - Fast path: out_valid high in the cycle right after the accept edge.
- DONE: out_valid=1; out_data and out_rd are held stable until out_valid && out_ready at an edge, then return to IDLE.
  - in_ready stays 0 in DONE, so there is no back-to-back overlap and the next accept is no earlier than the cycle after the handshake.
- rd==0: the op executes normally and out_rd=0; the GPR file discards the write.
- kill: at any edge where kill==1, go to IDLE with out_valid 0 next cycle.
  - This takes priority over a new accept and over a DONE handshake in the same cycle.
  - kill in IDLE without a request has no effect.
- Reset mid-operation: same as kill; all state is cleared.
- Inputs src1/src2/funct3/rd are don't-care outside an accept edge.

Test Plan:
- MUL 7 x -3 (src1=7, src2=0xFFFFFFFD), out_ready=1 -> out_data=0xFFFFFFEB, out_valid exactly 33 edges after accept, then in_ready=1.
- MULH/MULHSU/MULHU with src1=0xFFFFFFFF, src2=0xFFFFFFFF -> 0x00000000, 0xFFFFFFFF, 0xFFFFFFFE respectively.
- DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- DIVU 5/0 -> 0xFFFFFFFF and REM 5/0 -> 5, both with 1-cycle latency; DIV 0x80000000/0xFFFFFFFF -> 0x80000000.
- Hold out_ready=0 for 10 cycles in DONE -> out_valid, out_data, out_rd stable and in_ready=0; release -> one handshake, then IDLE.
- kill at CALC cnt=10 -> IDLE next cycle, no out_valid. Repeat with rst=0 at cnt=10 -> all outputs at reset values. A following MUL 3x4 -> 12.
